// File: rtl/fifo_read_control.sv
// Read-side control for a dual-clock FIFO: synchronizes the Gray write
// pointer into the read clock domain, keeps the read pointer, and produces
// the registered empty flag, fill level, popped data and underflow pulse.
module fifo_read_control #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock_read,
    input  logic                  reset_read_n,
    input  logic [ADDR_WIDTH:0]   write_pointer_gray,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic [ADDR_WIDTH:0]   read_pointer_gray,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fill_level
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wptr_sync;
    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic          pop;

    assign wptr_sync    = sync_q[SYNC_STAGES-1];
    assign read_address = rbin[ADDR_WIDTH-1:0];

    // Multi-flop synchronizer for the write pointer; only the last stage is consumed.
    always_ff @(posedge clock_read) begin
        if (!reset_read_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= write_pointer_gray;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Next-pointer computation; empty and fill look ahead at the post-pop pointer.
    always_comb begin
        pop        = read_enable & ~empty;
        rbin_next  = rbin + {{(PW-1){1'b0}}, pop};
        rgray_next = bin_to_gray(rbin_next);
        wptr_bin   = gray_to_bin(wptr_sync);
    end

    // Pointer, status flags and popped data; reset overrides any pop.
    always_ff @(posedge clock_read) begin
        if (!reset_read_n) begin
            rbin              <= '0;
            read_pointer_gray <= '0;
            empty             <= 1'b1;
            data_out          <= '0;
            data_valid        <= 1'b0;
            underflow         <= 1'b0;
            fill_level        <= '0;
        end else begin
            rbin              <= rbin_next;
            read_pointer_gray <= rgray_next;
            empty             <= (rgray_next == wptr_sync);
            fill_level        <= wptr_bin - rbin_next;
            underflow         <= read_enable & empty;
            data_valid        <= pop;
            if (pop) begin
                data_out <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_control.sv
// Directed bench for fifo_read_control: reset, single word, underflow,
// full drain, pointer wrap, simultaneous pop/write and mid-stream reset.
module tb_fifo_read_control;

    logic        clock_read = 1'b0;
    logic        reset_read_n;
    logic [6:0]  write_pointer_gray;
    logic [15:0] read_data;
    logic        read_enable;
    logic [5:0]  read_address;
    logic [6:0]  read_pointer_gray;
    logic        empty;
    logic [15:0] data_out;
    logic        data_valid;
    logic        underflow;
    logic [6:0]  fill_level;

    logic [15:0] rd_manual;
    logic        use_mem;
    int          checks = 0;
    int          errors = 0;

    // Memory model: word at address a is 16'hD000 + a when use_mem is set.
    assign read_data = use_mem ? (16'hD000 + {10'd0, read_address}) : rd_manual;

    always #5 clock_read = ~clock_read;

    fifo_read_control #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (6),
        .SYNC_STAGES(2)
    ) dut (
        .clock_read        (clock_read),
        .reset_read_n      (reset_read_n),
        .write_pointer_gray(write_pointer_gray),
        .read_data         (read_data),
        .read_enable       (read_enable),
        .read_address      (read_address),
        .read_pointer_gray (read_pointer_gray),
        .empty             (empty),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .underflow         (underflow),
        .fill_level        (fill_level)
    );

    task automatic tick();
        @(posedge clock_read);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] gray7(input logic [6:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        use_mem            = 1'b0;
        rd_manual          = 16'h0000;
        reset_read_n       = 1'b0;
        read_enable        = 1'b1;
        write_pointer_gray = 7'h05;

        // Reset held two edges with a pop request and a nonzero write pointer
        tick();
        tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_raddr", 32'(read_address), 32'd0);
        check("rst_rgray", 32'(read_pointer_gray), 32'd0);
        check("rst_dvalid", 32'(data_valid), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);

        // Single word
        reset_read_n       = 1'b1;
        read_enable        = 1'b0;
        write_pointer_gray = 7'h00;
        tick(); tick(); tick();
        check("idle_empty", 32'(empty), 32'd1);
        write_pointer_gray = 7'h01;
        tick();
        check("sw_empty_e1", 32'(empty), 32'd1);
        tick();
        check("sw_empty_e2", 32'(empty), 32'd1);
        tick();
        check("sw_empty_e3", 32'(empty), 32'd0);
        check("sw_fill_pre", 32'(fill_level), 32'd1);
        rd_manual   = 16'hA5A5;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        check("sw_dout", 32'(data_out), 32'hA5A5);
        check("sw_dvalid", 32'(data_valid), 32'd1);
        check("sw_empty", 32'(empty), 32'd1);
        check("sw_rgray", 32'(read_pointer_gray), 32'h01);
        check("sw_fill", 32'(fill_level), 32'd0);
        check("sw_raddr", 32'(read_address), 32'd1);
        rd_manual = 16'h1234;
        tick();
        check("sw_dvalid_drop", 32'(data_valid), 32'd0);
        check("sw_dout_hold", 32'(data_out), 32'hA5A5);

        // Underflow
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        check("uf_pulse", 32'(underflow), 32'd1);
        check("uf_raddr", 32'(read_address), 32'd1);
        check("uf_dvalid", 32'(data_valid), 32'd0);
        check("uf_rgray", 32'(read_pointer_gray), 32'h01);
        check("uf_dout", 32'(data_out), 32'hA5A5);
        tick();
        check("uf_clear", 32'(underflow), 32'd0);

        // Full drain: reset to pointer 0, then 64 words written
        reset_read_n       = 1'b0;
        write_pointer_gray = 7'h60;
        tick();
        reset_read_n = 1'b1;
        tick(); tick();
        check("fd_empty_e2", 32'(empty), 32'd1);
        tick();
        check("fd_empty_e3", 32'(empty), 32'd0);
        check("fd_fill64", 32'(fill_level), 32'd64);
        use_mem     = 1'b1;
        read_enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("fd_raddr_%0d", i), 32'(read_address), 32'(i));
            tick();
            check($sformatf("fd_dout_%0d", i), 32'(data_out), 32'(16'hD000 + i));
            check($sformatf("fd_dvalid_%0d", i), 32'(data_valid), 32'd1);
            check($sformatf("fd_empty_%0d", i), 32'(empty), (i == 63) ? 32'd1 : 32'd0);
            check($sformatf("fd_fill_%0d", i), 32'(fill_level), 32'(63 - i));
        end
        read_enable = 1'b0;
        check("fd_raddr_wrap", 32'(read_address), 32'd0);
        check("fd_rgray", 32'(read_pointer_gray), 32'h60);

        // Pointer wrap: write pointer advances to 128 (Gray 7'h00)
        write_pointer_gray = 7'h00;
        tick(); tick();
        check("wr_empty_e2", 32'(empty), 32'd1);
        tick();
        check("wr_empty_e3", 32'(empty), 32'd0);
        check("wr_fill64", 32'(fill_level), 32'd64);
        read_enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic [6:0] b;
            b = 7'(65 + i);
            tick();
            check($sformatf("wr_dout_%0d", i), 32'(data_out), 32'(16'hD000 + i));
            check($sformatf("wr_rgray_%0d", i), 32'(read_pointer_gray), 32'(gray7(b)));
            check($sformatf("wr_empty_%0d", i), 32'(empty), (i == 63) ? 32'd1 : 32'd0);
            check($sformatf("wr_underflow_%0d", i), 32'(underflow), 32'd0);
            if (i == 62) check("wr_rgray_127", 32'(read_pointer_gray), 32'h40);
            if (i == 63) check("wr_rgray_0", 32'(read_pointer_gray), 32'h00);
        end
        read_enable = 1'b0;

        // Pop and write in the same cycle
        write_pointer_gray = 7'h01;
        tick(); tick(); tick();
        check("pw_empty_pre", 32'(empty), 32'd0);
        check("pw_fill_pre", 32'(fill_level), 32'd1);
        write_pointer_gray = 7'h03;
        read_enable        = 1'b1;
        tick();
        read_enable = 1'b0;
        check("pw_dvalid", 32'(data_valid), 32'd1);
        check("pw_empty_e1", 32'(empty), 32'd1);
        check("pw_fill_e1", 32'(fill_level), 32'd0);
        tick();
        check("pw_empty_e2", 32'(empty), 32'd1);
        tick();
        check("pw_empty_e3", 32'(empty), 32'd0);
        check("pw_fill_e3", 32'(fill_level), 32'd1);

        // Mid-stream reset
        reset_read_n       = 1'b0;
        write_pointer_gray = 7'h0F;
        tick();
        reset_read_n = 1'b1;
        tick(); tick(); tick();
        check("ms_fill10", 32'(fill_level), 32'd10);
        read_enable = 1'b1;
        tick(); tick(); tick();
        check("ms_raddr3", 32'(read_address), 32'd3);
        check("ms_fill7", 32'(fill_level), 32'd7);
        reset_read_n = 1'b0;
        tick();
        read_enable = 1'b0;
        check("ms_rst_raddr", 32'(read_address), 32'd0);
        check("ms_rst_rgray", 32'(read_pointer_gray), 32'd0);
        check("ms_rst_empty", 32'(empty), 32'd1);
        check("ms_rst_dvalid", 32'(data_valid), 32'd0);
        reset_read_n = 1'b1;
        tick();
        check("ms_empty_e1", 32'(empty), 32'd1);
        tick();
        check("ms_empty_e2", 32'(empty), 32'd1);
        tick();
        check("ms_empty_e3", 32'(empty), 32'd0);
        check("ms_fill_e3", 32'(fill_level), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_control.md
FIFO_READ_CONTROL -- requirements
Module: fifo_read_control

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 6, giving the address width for a 64-word memory.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, giving the pointer synchronizer depth (minimum 2).
REQ-004 The module SHALL have port clock_read, input, width 1: the single clock; all flops use its rising edge.
REQ-005 The module SHALL have port reset_read_n, input, width 1: reset, synchronous and active-low.
REQ-006 The module SHALL have port write_pointer_gray, input, width ADDR_WIDTH+1: Gray-coded write pointer from the write domain (address bits plus wrap bit).
REQ-007 The module SHALL have port read_data, input, width DATA_WIDTH: memory word at read_address (combinational memory read).
REQ-008 The module SHALL have port read_enable, input, width 1: consumer pop request.
REQ-009 The module SHALL have port read_address, output, width ADDR_WIDTH: memory read address.
REQ-010 The module SHALL have port read_pointer_gray, output, width ADDR_WIDTH+1: registered Gray read pointer, sent to the write domain.
REQ-011 The module SHALL have port empty, output, width 1: registered empty flag.
REQ-012 The module SHALL have port data_out, output, width DATA_WIDTH: registered popped word.
REQ-013 The module SHALL have port data_valid, output, width 1: data_out was loaded on the last edge.
REQ-014 The module SHALL have port underflow, output, width 1: one-cycle pulse flagging a rejected pop.
REQ-015 The module SHALL have port fill_level, output, width ADDR_WIDTH+1: registered word count, 0..64.

Function
REQ-016 write_pointer_gray SHALL pass through SYNC_STAGES flops; the last stage (wptr_sync) SHALL be the only write-domain value used.
REQ-017 The read pointer SHALL be held as an (ADDR_WIDTH+1)-bit binary counter rbin; read_address = rbin[ADDR_WIDTH-1:0]; read_pointer_gray SHALL register rbin_next ^ (rbin_next >> 1).
REQ-018 pop = read_enable & ~empty; on pop: rbin increments modulo 2^(ADDR_WIDTH+1) (127 -> 0), so read_address wraps 63 -> 0.
REQ-019 On pop: data_out <= read_data and data_valid <= 1. Otherwise data_valid <= 0 and data_out holds its value.
REQ-020 empty SHALL register (Gray(rbin_next) == wptr_sync), so a pop of the last word sets empty on the same edge as the pop.
REQ-021 A write-pointer change at the input SHALL deassert empty on the (SYNC_STAGES+1)th rising edge after the change (3rd edge at default).
REQ-022 underflow SHALL register read_enable & empty; on underflow, rbin, data_out and read_pointer_gray SHALL remain unchanged.
REQ-023 fill_level SHALL register (binary(wptr_sync) - rbin_next) mod 2^(ADDR_WIDTH+1); full at the write side (pointers differing only in the MSB) SHALL give 64.
REQ-024 A pop and a write-pointer change in the same cycle SHALL both take effect; empty and fill_level SHALL reflect both.

Reset
REQ-025 When reset_read_n = 0 at a rising edge, the following SHALL be set: rbin = 0, read_pointer_gray = 0, all synchronizer flops = 0, empty = 1, data_out = 0, data_valid = 0, underflow = 0, fill_level = 0.
REQ-026 Reset SHALL override a simultaneous pop, including a reset asserted mid-stream.

Verification
REQ-027 Reset: reset_read_n = 0 for 2 edges with read_enable = 1 and write_pointer_gray = 7'h05 -> empty = 1, read_address = 0, read_pointer_gray = 0, data_valid = 0, underflow = 0.
REQ-028 Single word: write_pointer_gray 0 -> 7'h01 -> empty falls on the 3rd edge; then read_data = 16'hA5A5 and a 1-cycle read_enable -> next edge: data_out = 16'hA5A5, data_valid = 1, empty = 1, read_pointer_gray = 7'h01, fill_level = 0.
REQ-029 Underflow: empty = 1 and read_enable = 1 for 1 cycle -> underflow = 1 for exactly one cycle, read_address unchanged, data_valid = 0.
REQ-030 Full drain: write_pointer_gray = 7'h60 (64 words) -> fill_level = 64; 64 consecutive pops -> read_address 0..63 then 0, empty = 1 on the 64th pop edge, read_pointer_gray = 7'h60.
REQ-031 Pointer wrap: continue to 128 total pops with the write pointer advancing -> read_pointer_gray passes 7'h40 (pointer 127) and then 7'h00; no spurious empty or underflow.
REQ-032 Mid-stream reset: write_pointer_gray = 7'h0F (10 words), pop 3, then reset with read_enable = 1 -> pointers 0, empty = 1, data_valid = 0; after release, empty falls on the 3rd edge and fill_level = 10.
